// File: rtl/mod_determinante_seq.sv
// Sequential signed determinant (2x2 / 3x3) that time-shares one multiplier.
// Optional macro DET_SATURATE_EN: clamp resultado on overflow instead of wrapping.
module mod_determinante_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 modo,
  input  logic [9*WIDTH-1:0]   matriz,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     resultado,
  output logic [3*WIDTH+2:0]   resultado_full,
  output logic                 overflow
);

  localparam int FULL_W = 3*WIDTH+3;
  localparam logic signed [FULL_W-1:0] MAXV = FULL_W'(2**(WIDTH-1)-1);
  localparam logic signed [FULL_W-1:0] MINV = FULL_W'(-(2**(WIDTH-1)));

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_LDMIN, OP_SUBMIN, OP_ADDACC, OP_SUBACC, OP_LDACC} op_t;

  state_t                     state;
  logic [9*WIDTH-1:0]         mreg;
  logic                       modo_r;
  logic [3:0]                 step;
  logic signed [FULL_W-1:0]   acc;
  logic signed [FULL_W-1:0]   minor;

  logic signed [FULL_W-1:0]   e [9];
  logic signed [FULL_W-1:0]   opa, opb, prod;
  logic signed [FULL_W-1:0]   acc_next, minor_next;
  logic                       last_step;
  logic                       ovf_next;
  logic [WIDTH-1:0]           res_next;
  op_t                        op;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      e[k] = FULL_W'(signed'(mreg[k*WIDTH +: WIDTH]));
    end
  end

  // Step schedule: 3x3 runs three steps per cofactor term (two products build
  // the minor, the third scales it by the row-0 element into the accumulator).
  always_comb begin
    opa       = '0;
    opb       = '0;
    op        = OP_NONE;
    last_step = 1'b0;
    if (modo_r) begin
      case (step)
        4'd0: begin opa = e[4]; opb = e[8];  op = OP_LDMIN;  end
        4'd1: begin opa = e[5]; opb = e[7];  op = OP_SUBMIN; end
        4'd2: begin opa = e[0]; opb = minor; op = OP_ADDACC; end
        4'd3: begin opa = e[3]; opb = e[8];  op = OP_LDMIN;  end
        4'd4: begin opa = e[5]; opb = e[6];  op = OP_SUBMIN; end
        4'd5: begin opa = e[1]; opb = minor; op = OP_SUBACC; end
        4'd6: begin opa = e[3]; opb = e[7];  op = OP_LDMIN;  end
        4'd7: begin opa = e[4]; opb = e[6];  op = OP_SUBMIN; end
        4'd8: begin opa = e[2]; opb = minor; op = OP_ADDACC; last_step = 1'b1; end
        default: ;
      endcase
    end else begin
      case (step)
        4'd0: begin opa = e[0]; opb = e[4]; op = OP_LDACC; end
        4'd1: begin opa = e[1]; opb = e[3]; op = OP_SUBACC; last_step = 1'b1; end
        default: ;
      endcase
    end
  end

  assign prod = opa * opb;

  always_comb begin
    acc_next   = acc;
    minor_next = minor;
    case (op)
      OP_LDMIN:  minor_next = prod;
      OP_SUBMIN: minor_next = minor - prod;
      OP_ADDACC: acc_next   = acc + prod;
      OP_SUBACC: acc_next   = acc - prod;
      OP_LDACC:  acc_next   = prod;
      default: ;
    endcase
  end

  always_comb begin
    ovf_next = (acc_next > MAXV) || (acc_next < MINV);
`ifdef DET_SATURATE_EN
    if (acc_next > MAXV)
      res_next = MAXV[WIDTH-1:0];
    else if (acc_next < MINV)
      res_next = MINV[WIDTH-1:0];
    else
      res_next = acc_next[WIDTH-1:0];
`else
    res_next = acc_next[WIDTH-1:0];
`endif
  end

  // Control FSM; start is ignored while done is high so a new request lands
  // in the cycle after the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mreg           <= '0;
      modo_r         <= 1'b0;
      step           <= '0;
      acc            <= '0;
      minor          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      resultado      <= '0;
      resultado_full <= '0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            mreg   <= matriz;
            modo_r <= modo;
            acc    <= '0;
            minor  <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          minor <= minor_next;
          step  <= step + 4'd1;
          if (last_step) begin
            resultado_full <= acc_next;
            overflow       <= ovf_next;
            resultado      <= res_next;
            state          <= FIM;
          end
        end
        FIM: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_determinante_seq.sv
// Directed self-checking bench for mod_determinante_seq (WIDTH=8).
module tb_mod_determinante_seq;
  localparam int WIDTH  = 8;
  localparam int FULL_W = 3*WIDTH+3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic               modo = 1'b0;
  logic [9*WIDTH-1:0] matriz = '0;
  logic               busy, done, overflow;
  logic [WIDTH-1:0]   resultado;
  logic [FULL_W-1:0]  resultado_full;

  int checks = 0;
  int failures = 0;
  int lat, busyCnt, doneCnt;

  mod_determinante_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .modo(modo), .matriz(matriz),
    .busy(busy), .done(done), .resultado(resultado),
    .resultado_full(resultado_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [9*WIDTH-1:0] packM(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    packM = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic longint pick(input longint wrapVal, input longint satVal);
`ifdef DET_SATURATE_EN
    pick = satVal;
`else
    pick = wrapVal;
`endif
  endfunction

  // Start one operation and watch a fixed window of edges; optionally
  // disturb start/matriz/modo while the unit is calculating.
  task automatic applyStimulus(input logic md, input logic [9*WIDTH-1:0] m, input bit disturb);
    @(posedge clk); #1;
    modo = md; matriz = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; doneCnt = 0;
    busyCnt = busy ? 1 : 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (lat < 0) lat = n;
      end
      if (disturb && n == 2) begin start = 1'b1; matriz = ~m; modo = ~md; end
      if (disturb && n == 3) start = 1'b0;
    end
  endtask

  task automatic checkResult(input string tag, input longint expFull, input longint expRes,
                             input logic expOv, input int expLat);
    checkOutput({tag, "_full"}, longint'($signed(resultado_full)), expFull);
    checkOutput({tag, "_res"}, longint'(resultado), expRes);
    checkOutput({tag, "_ovf"}, longint'(overflow), longint'(expOv));
    checkOutput({tag, "_lat"}, longint'(lat), longint'(expLat));
    checkOutput({tag, "_busy"}, longint'(busyCnt), longint'(expLat));
    checkOutput({tag, "_dones"}, longint'(doneCnt), 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_done", longint'(done), 0);
    checkOutput("rst_res", longint'(resultado), 0);
    checkOutput("rst_full", longint'(resultado_full), 0);
    checkOutput("rst_ovf", longint'(overflow), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    applyStimulus(1'b0, packM(1, 2, 9, 3, 4, 9, 9, 9, 9), 1'b0);
    checkResult("t1", -2, 'hFE, 1'b0, 3);
    applyStimulus(1'b0, packM(2, 1, 7, 4, 5, 7, 7, 7, 7), 1'b0);
    checkResult("t2a", 6, 6, 1'b0, 3);
    applyStimulus(1'b0, packM(3, 3, 0, 3, 3, 0, 0, 0, 0), 1'b0);
    checkResult("t2b", 0, 0, 1'b0, 3);
    applyStimulus(1'b1, packM(2, 0, 1, 1, 3, 2, 1, 1, 1), 1'b0);
    checkResult("t3", 0, 0, 1'b0, 10);
    applyStimulus(1'b1, packM(6, 1, 1, 4, -2, 5, 2, 8, 7), 1'b0);
    checkResult("t4", -306, pick('hCE, 'h80), 1'b1, 10);
    applyStimulus(1'b0, packM(1, 2, 9, 3, 4, 9, 9, 9, 9), 1'b0);
    checkResult("t4b", -2, 'hFE, 1'b0, 3);
    applyStimulus(1'b1, packM(6, 1, 1, 4, -2, 5, 2, 8, 7), 1'b1);
    checkResult("t5", -306, pick('hCE, 'h80), 1'b1, 10);
    applyStimulus(1'b1, packM(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    checkResult("zero", 0, 0, 1'b0, 10);
    applyStimulus(1'b0, packM(-128, 0, 5, 0, -128, 5, 5, 5, 5), 1'b0);
    checkResult("neg2", 16384, pick('h00, 'h7F), 1'b1, 3);
    applyStimulus(1'b1, packM(-128, 0, 0, 0, -128, 0, 0, 0, -128), 1'b0);
    checkResult("neg3", -2097152, pick('h00, 'h80), 1'b1, 10);

    // Abort a 3x3 operation with reset part-way through.
    @(posedge clk); #1;
    modo = 1'b1; matriz = packM(6, 1, 1, 4, -2, 5, 2, 8, 7); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", longint'(busy), 0);
    checkOutput("abort_done", longint'(done), 0);
    checkOutput("abort_res", longint'(resultado), 0);
    checkOutput("abort_full", longint'(resultado_full), 0);
    checkOutput("abort_ovf", longint'(overflow), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    doneCnt = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done) doneCnt++;
    end
    checkOutput("abort_nodone", longint'(doneCnt), 0);
    applyStimulus(1'b0, packM(2, 1, 7, 4, 5, 7, 7, 7, 7), 1'b0);
    checkResult("after_rst", 6, 6, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
